rs_syndrome_calc: RTL and testbench

Serial syndrome stage at the front of the RS(15,11) GF(16) decoder. It accepts one 4-bit received symbol per cycle, highest-degree coefficient r14 first, and evaluates r(x) at the four generator roots by Horner's rule. Each root uses its own constant GF multiplier. At the end of each 15-symbol block it presents S1..S4 with a one-cycle valid pulse to the downstream key-equation solver.

---
 rtl/rs_gf16_pkg.sv | 37 +++
 rtl/gf16_mult_const.sv | 13 +
 rtl/rs_syndrome_calc.sv | 119 +++++++++++
 tb/tb_rs_syndrome_calc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf16_pkg.sv
// GF(16) constants and constant-multiply helper for the RS(15,11) decoder front end.
// Field polynomial x^4+x+1; ALPHA_POW[i] holds alpha^i in polynomial basis.
package rs_gf16_pkg;

   localparam int SYM_W  = 4;
   localparam int N_FULL = 15;
   localparam int K      = 11;
   localparam int NROOTS = 4;
   localparam logic [4:0] GF_POLY = 5'b10011;

   // Packed so that element 0 is the least significant nibble (alpha^0 = 1).
   localparam logic [14:0][3:0] ALPHA_POW = {
      4'h9, 4'hd, 4'hf, 4'he, 4'h7, 4'ha, 4'h5, 4'hb,
      4'hc, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
   };

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } synd_state_e;

   // Shift-and-add product of sym with the constant alpha^exp.
   function automatic logic [3:0] gf_mul_const(input logic [3:0] sym, input int exp);
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] p;
      a = sym;
      b = ALPHA_POW[4'(exp % 15)];
      p = 4'h0;
      for (int i = 0; i < SYM_W; i++) begin
         if (b[i]) p = p ^ a;
         a = a[3] ? ({a[2:0], 1'b0} ^ GF_POLY[3:0]) : {a[2:0], 1'b0};
      end
      return p;
   endfunction

endpackage

// File: rtl/gf16_mult_const.sv
// Combinational GF(16) multiply of a symbol by the fixed constant alpha^EXP.
module gf16_mult_const
   import rs_gf16_pkg::*;
#(
   parameter int EXP = 1
) (
   input  logic [3:0] i_sym,
   output logic [3:0] o_prod
);

   assign o_prod = gf_mul_const(i_sym, EXP);

endmodule

// File: rtl/rs_syndrome_calc.sv
// Serial Horner syndrome calculator for RS(15,11) over GF(16), one symbol per cycle, r14 first.
// Optional RS_SYND_ERRFLAG_EN adds OUT_ERR, set when any syndrome bit is nonzero.
module rs_syndrome_calc
   import rs_gf16_pkg::*;
#(
   parameter int N   = 15,
   parameter int FCR = 1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       IN_VALID,
   input  logic       IN_SOB,
   input  logic [3:0] IN_SYM,
   output logic       OUT_VALID,
   output logic [3:0] OUT_S1,
   output logic [3:0] OUT_S2,
   output logic [3:0] OUT_S3,
   output logic [3:0] OUT_S4
`ifdef RS_SYND_ERRFLAG_EN
   ,
   output logic       OUT_ERR
`endif
);

   synd_state_e r_state;
   synd_state_e w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [3:0]  r_acc      [NROOTS];
   logic [3:0]  w_acc_nxt  [NROOTS];
   logic [3:0]  w_acc_mul  [NROOTS];
   logic [3:0]  w_step     [NROOTS];
   logic [3:0]  r_synd     [NROOTS];
   logic [3:0]  w_synd_nxt [NROOTS];
   logic        r_valid;
   logic        w_valid_nxt;
   logic        w_first;
   logic        w_last;

   genvar g;
   generate
      for (g = 0; g < NROOTS; g++) begin : g_root
         gf16_mult_const #(.EXP((FCR + g) % 15)) u_mul (
            .i_sym  (r_acc[g]),
            .o_prod (w_acc_mul[g])
         );
         assign w_step[g] = w_acc_mul[g] ^ IN_SYM;
      end
   endgenerate

   // A start-of-block marker always wins, so a restart never completes the old block.
   assign w_first = (r_state == ST_IDLE) || IN_SOB;
   assign w_last  = (r_cnt == 4'(N - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      w_synd_nxt  = r_synd;
      w_valid_nxt = 1'b0;
      if (IN_VALID) begin
         if (w_first) begin
            for (int j = 0; j < NROOTS; j++) w_acc_nxt[j] = IN_SYM;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = ST_ACCUM;
         end else if (w_last) begin
            for (int j = 0; j < NROOTS; j++) begin
               w_synd_nxt[j] = w_step[j];
               w_acc_nxt[j]  = 4'h0;
            end
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_IDLE;
         end else begin
            w_acc_nxt = w_step;
            w_cnt_nxt = r_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         for (int j = 0; j < NROOTS; j++) begin
            r_acc[j]  <= 4'h0;
            r_synd[j] <= 4'h0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         r_acc   <= w_acc_nxt;
         r_synd  <= w_synd_nxt;
      end
   end

`ifdef RS_SYND_ERRFLAG_EN
   logic r_err;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_err <= 1'b0;
      end else if (w_valid_nxt) begin
         r_err <= |{w_synd_nxt[0], w_synd_nxt[1], w_synd_nxt[2], w_synd_nxt[3]};
      end
   end

   assign OUT_ERR = r_err;
`endif

   assign OUT_VALID = r_valid;
   assign OUT_S1    = r_synd[0];
   assign OUT_S2    = r_synd[1];
   assign OUT_S3    = r_synd[2];
   assign OUT_S4    = r_synd[3];

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Randomized bench for rs_syndrome_calc: syndromes are predicted by direct evaluation of r(x)
// at alpha^FCR..alpha^(FCR+3) and compared at every OUT_VALID pulse.
module tb_rs_syndrome_calc;

   localparam int N   = 15;
   localparam int FCR = 1;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       IN_VALID = 1'b0;
   logic       IN_SOB = 1'b0;
   logic [3:0] IN_SYM = 4'h0;
   logic       OUT_VALID;
   logic [3:0] OUT_S1, OUT_S2, OUT_S3, OUT_S4;
`ifdef RS_SYND_ERRFLAG_EN
   logic       OUT_ERR;
`endif

   rs_syndrome_calc #(.N(N), .FCR(FCR)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_SOB    (IN_SOB),
      .IN_SYM    (IN_SYM),
      .OUT_VALID (OUT_VALID),
      .OUT_S1    (OUT_S1),
      .OUT_S2    (OUT_S2),
      .OUT_S3    (OUT_S3),
      .OUT_S4    (OUT_S4)
`ifdef RS_SYND_ERRFLAG_EN
      ,
      .OUT_ERR   (OUT_ERR)
`endif
   );

   // clock / reset
   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_valid  = 0;
   int          cyc      = 0;
   int          valid_cyc[$];
   logic [15:0] exp_q[$];
   logic [3:0]  blk [15];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // reference model: plain GF(16) arithmetic and direct polynomial evaluation
   function automatic int gf_mul(input int a, input int b);
      int p;
      int aa;
      p  = 0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if ((b >> i) & 1) p = p ^ aa;
         aa = aa << 1;
         if (aa & 16) aa = aa ^ 19;
      end
      return p;
   endfunction

   function automatic int alpha_pow(input int e);
      int p;
      p = 1;
      for (int i = 0; i < (e % 15); i++) p = gf_mul(p, 2);
      return p;
   endfunction

   function automatic logic [15:0] model_synd(input logic [3:0] b [15]);
      logic [15:0] res;
      res = 16'h0;
      for (int j = 0; j < 4; j++) begin
         int s;
         s = 0;
         for (int k = 0; k < N; k++)
            s = s ^ gf_mul(int'(b[k]), alpha_pow((FCR + j) * (N - 1 - k)));
         res[15 - 4*j -: 4] = 4'(s);
      end
      return res;
   endfunction

   // monitor / scoreboard
   always @(negedge CLK) begin
      cyc++;
      if (OUT_VALID) begin
         n_valid++;
         valid_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_valid", 32'(OUT_VALID), 32'd0);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check_eq("synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'(e));
`ifdef RS_SYND_ERRFLAG_EN
            check_eq("err_flag", 32'(OUT_ERR), 32'(|e));
`endif
         end
      end
   end

   // drivers
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_sym(input logic [3:0] sym, input logic sob, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            IN_VALID = 1'b0;
            IN_SOB   = 1'($urandom_range(0, 1));
            IN_SYM   = 4'($urandom);
            tick();
         end
      end
      IN_VALID = 1'b1;
      IN_SOB   = sob;
      IN_SYM   = sym;
      tick();
      IN_VALID = 1'b0;
      IN_SOB   = 1'b0;
   endtask

   task automatic send_block(input logic sob_first, input bit gaps);
      exp_q.push_back(model_synd(blk));
      for (int k = 0; k < N; k++) send_sym(blk[k], (k == 0) ? sob_first : 1'b0, gaps);
   endtask

   task automatic drain(input string tag);
      repeat (3) tick();
      check_eq(tag, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic set_zero_blk();
      for (int k = 0; k < N; k++) blk[k] = 4'h0;
   endtask

   task automatic set_gx_blk();
      set_zero_blk();
      blk[10] = 4'd1;  blk[11] = 4'd13; blk[12] = 4'd12;
      blk[13] = 4'd8;  blk[14] = 4'd7;
   endtask

   initial begin
      int nv;
      // reset state
      RST_N = 1'b0;
      repeat (3) tick();
      check_eq("reset_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h0);
      check_eq("reset_valid", 32'(OUT_VALID), 32'd0);
      RST_N = 1'b1;
      tick();

      set_zero_blk();
      send_block(1'b0, 1'b0);
      drain("zero_drain");
      check_eq("zero_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h0000);

      set_gx_blk();
      send_block(1'b1, 1'b0);
      drain("gx_drain");
      check_eq("gx_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h0000);

      set_zero_blk();
      blk[14] = 4'd1;
      send_block(1'b0, 1'b0);
      drain("e0_drain");
      check_eq("e0_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h1111);

      set_zero_blk();
      blk[13] = 4'd1;
      send_block(1'b0, 1'b0);
      drain("e1_drain");
      check_eq("e1_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h2483);
      send_block(1'b0, 1'b1);
      drain("e1_gap_drain");
      check_eq("e1_gap_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h2483);
      repeat (6) tick();
      check_eq("hold_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h2483);

      // back-to-back blocks with no bubble
      valid_cyc.delete();
      set_zero_blk();
      blk[14] = 4'd1;
      send_block(1'b1, 1'b0);
      set_zero_blk();
      blk[13] = 4'd1;
      send_block(1'b1, 1'b0);
      drain("b2b_drain");
      check_eq("b2b_pulses", 32'(valid_cyc.size()), 32'd2);
      if (valid_cyc.size() == 2)
         check_eq("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd15);

      // partial block discarded by an SOB restart
      nv = n_valid;
      for (int k = 0; k < 7; k++) send_sym(4'($urandom), (k == 0), 1'b0);
      set_gx_blk();
      send_block(1'b1, 1'b1);
      drain("restart_drain");
      check_eq("restart_pulses", 32'(n_valid - nv), 32'd1);
      check_eq("restart_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h0000);

      // reset mid-block
      set_zero_blk();
      blk[14] = 4'd1;
      send_block(1'b1, 1'b0);
      drain("pre_rst_drain");
      nv = n_valid;
      for (int k = 0; k < 8; k++) send_sym(4'($urandom_range(1, 15)), (k == 0), 1'b0);
      RST_N = 1'b0;
      #1;
      check_eq("midrst_synd", {OUT_S1, OUT_S2, OUT_S3, OUT_S4}, 32'h0);
      check_eq("midrst_valid", 32'(OUT_VALID), 32'd0);
      tick();
      RST_N = 1'b1;
      for (int k = 0; k < 7; k++) send_sym(4'($urandom), 1'b0, 1'b0);
      repeat (20) tick();
      check_eq("midrst_no_pulse", 32'(n_valid - nv), 32'd0);

      // random blocks, random gaps and ignored SOB during gaps
      for (int b = 0; b < 12; b++) begin
         for (int k = 0; k < N; k++) blk[k] = 4'($urandom);
         send_block(1'b1, bit'($urandom_range(0, 1)));
      end
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
